// File: rtl/unidade_busca_if.sv
// unidade_busca_if: PC-stage handshake, instruction-memory bus and decode-side head of the fetch unit
// master: fetch-unit side (drives pc_pronto, memory request, instruction head)
// slave: surrounding PC stage, instruction memory and decode (drive address, response, flush, consume)
interface unidade_busca_if;
    logic [31:0] endereco_pc;
    logic        pc_valido;
    logic        pc_pronto;
    logic        mem_req;
    logic [31:0] mem_endereco;
    logic        mem_valido;
    logic [31:0] mem_dado;
    logic        flush;
    logic        inst_valida;
    logic        inst_pronta;
    logic [31:0] instrucao;
    logic [31:0] inst_endereco;
    logic [31:0] imediato;
    logic        eh_desvio;
    logic        desalinhado;
    modport master (
        input  endereco_pc, pc_valido, mem_valido, mem_dado, flush, inst_pronta,
        output pc_pronto, mem_req, mem_endereco, inst_valida, instrucao, inst_endereco,
               imediato, eh_desvio, desalinhado
    );
    modport slave (
        output endereco_pc, pc_valido, mem_valido, mem_dado, flush, inst_pronta,
        input  pc_pronto, mem_req, mem_endereco, inst_valida, instrucao, inst_endereco,
               imediato, eh_desvio, desalinhado
    );
endinterface

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit with one outstanding variable-latency read and a PROF-entry FIFO
// Ports: clock, reset (synchronous, active-high); bus (unidade_busca_if.master) carrying the
// PC-stage address handshake, the memory request/response pair and the decode-side FIFO head
// (instruction, address, B-type immediate, branch flag, misaligned flag).
module unidade_busca #(
    parameter int PROF = 2
) (
    input logic             clock,
    input logic             reset,
    unidade_busca_if.master bus
);
    localparam int PW = $clog2(PROF);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CHEIO = CW'(PROF);
    typedef enum logic {OCIOSO, ESPERA_MEM} estado_t;
    estado_t       estado_q, estado_d;
    logic          descartar_q, descartar_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_endereco_q, mem_endereco_d;
    logic [CW-1:0] contador_q, contador_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   inst_q [PROF];
    logic [31:0]   end_q [PROF];
    logic [PROF-1:0] desal_q;
    logic          aceita, alinhado, resposta, push, pop;
    logic [31:0]   push_inst, push_end, cabeca;
    // contador counts only landed entries; the single in-flight fetch needs no explicit
    // reservation because no new accept can happen until it returns
    assign bus.pc_pronto = (estado_q == OCIOSO) && (contador_q < CHEIO) && !bus.flush;
    assign aceita    = bus.pc_valido && bus.pc_pronto;
    assign alinhado  = bus.endereco_pc[1:0] == 2'b00;
    assign resposta  = (estado_q == ESPERA_MEM) && bus.mem_valido;
    // misaligned addresses skip memory and enqueue a NOP at once
    assign push      = (aceita && !alinhado) || (resposta && !descartar_q && !bus.flush);
    assign pop       = bus.inst_valida && bus.inst_pronta && !bus.flush;
    assign push_inst = resposta ? bus.mem_dado : 32'h0000_0013;
    assign push_end  = resposta ? mem_endereco_q : bus.endereco_pc;
    always_comb begin
        mem_req_d      = aceita && alinhado;
        mem_endereco_d = mem_req_d ? bus.endereco_pc : mem_endereco_q;
        estado_d       = mem_req_d ? ESPERA_MEM : resposta ? OCIOSO : estado_q;
        // a flush while waiting cannot cancel the bus cycle, so the response is marked for dropping
        descartar_d    = resposta ? 1'b0 : (estado_q == ESPERA_MEM && bus.flush) ? 1'b1 : descartar_q;
        wr_d           = bus.flush ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d           = bus.flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
        contador_d     = bus.flush ? '0 : contador_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            descartar_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_endereco_q <= '0;
            contador_q     <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
        end else begin
            estado_q       <= estado_d;
            descartar_q    <= descartar_d;
            mem_req_q      <= mem_req_d;
            mem_endereco_q <= mem_endereco_d;
            contador_q     <= contador_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            inst_q[wr_q]  <= push_inst;
            end_q[wr_q]   <= push_end;
            desal_q[wr_q] <= !resposta;
        end
    end
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_endereco  = mem_endereco_q;
    assign bus.inst_valida   = contador_q != '0;
    // head fields are forced to zero when empty so stale slots never leak out
    assign cabeca            = bus.inst_valida ? inst_q[rd_q] : '0;
    assign bus.instrucao     = cabeca;
    assign bus.inst_endereco = bus.inst_valida ? end_q[rd_q] : '0;
    assign bus.desalinhado   = bus.inst_valida && desal_q[rd_q];
    assign bus.imediato      = {{20{cabeca[31]}}, cabeca[7], cabeca[30:25], cabeca[11:8], 1'b0};
    assign bus.eh_desvio     = cabeca[6:0] == 7'b1100011;
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: randomized scoreboard bench for the fetch unit against a queue-based reference model
module tb_unidade_busca;
    localparam int PROF = 2;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] i;
        logic        d;
    } ent_t;
    logic clock, reset;
    int checks = 0, errors = 0;
    bit mon_on = 0, resp_on = 0, spur = 0;
    int lat_cfg = 0;
    logic [31:0] mem_tab [logic [31:0]];
    ent_t fq[$];
    ent_t pend;
    bit pend_v = 0, pend_drop = 0, req_exp = 0;
    unidade_busca_if b();
    unidade_busca #(.PROF(PROF)) dut (.clock(clock), .reset(reset), .bus(b));
    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_tab.exists(a)) return mem_tab[a];
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction
    // branch offset assembled arithmetically from the B-type fields
    function automatic logic [31:0] imm_ref(input logic [31:0] i);
        int v;
        v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - int'(i[31]) * 4096;
        return 32'(v);
    endfunction
    // memory responder: fixed or random latency, optional spurious strobes while idle
    initial begin
        bit busy;
        int cnt;
        logic [31:0] r;
        busy = 0;
        cnt = 0;
        b.mem_valido = 1;
        b.mem_dado = '1;
        forever begin
            @(negedge clock);
            if (!resp_on) begin
                b.mem_valido = 1;
                b.mem_dado = '1;
                continue;
            end
            r = $urandom;
            b.mem_valido = 0;
            b.mem_dado = r;
            if (b.mem_req) begin
                busy = 1;
                cnt = lat_cfg < 0 ? int'($urandom_range(0, 3)) : lat_cfg;
            end
            if (busy) begin
                if (cnt == 0) begin
                    b.mem_valido = 1;
                    b.mem_dado = mem_word(b.mem_endereco);
                    busy = 0;
                end else cnt--;
            end else if (spur && $urandom_range(0, 7) == 0) b.mem_valido = 1;
        end
    end
    // monitor/scoreboard: checks outputs before each edge, then advances the model across it
    initial begin
        bit pr_exp, acc, ali;
        ent_t e;
        forever begin
            @(negedge clock);
            #3;
            if (!mon_on) continue;
            pr_exp = !pend_v && fq.size() < PROF && !b.flush;
            chk("pc_pronto", b.pc_pronto, pr_exp);
            chk("mem_req", b.mem_req, req_exp);
            if (pend_v) chk("mem_endereco", b.mem_endereco, pend.a);
            chk("inst_valida", b.inst_valida, fq.size() != 0);
            if (fq.size() != 0) begin
                e = fq[0];
                chk("instrucao", b.instrucao, e.i);
                chk("inst_endereco", b.inst_endereco, e.a);
                chk("imediato", b.imediato, imm_ref(e.i));
                chk("eh_desvio", b.eh_desvio, e.i[6:0] == 7'h63);
                chk("desalinhado", b.desalinhado, e.d);
            end else begin
                chk("instrucao_vazia", b.instrucao, 0);
                chk("inst_endereco_vazio", b.inst_endereco, 0);
                chk("imediato_vazio", b.imediato, 0);
                chk("flags_vazias", {b.eh_desvio, b.desalinhado}, 0);
            end
            acc = b.pc_valido && pr_exp;
            ali = b.endereco_pc[1:0] == 2'b00;
            req_exp = acc && ali;
            if (b.flush) begin
                fq.delete();
                if (pend_v) pend_drop = 1;
            end else if (fq.size() != 0 && b.inst_pronta) void'(fq.pop_front());
            if (pend_v && b.mem_valido) begin
                if (!pend_drop && !b.flush) fq.push_back(pend);
                pend_v = 0;
                pend_drop = 0;
            end
            if (acc) begin
                e.a = b.endereco_pc;
                if (ali) begin
                    e.i = mem_word(b.endereco_pc);
                    e.d = 0;
                    pend = e;
                    pend_v = 1;
                    pend_drop = 0;
                end else begin
                    e.i = 32'h0000_0013;
                    e.d = 1;
                    fq.push_back(e);
                end
            end
        end
    end
    task automatic oferta(input logic [31:0] a, input int lim, output bit ok);
        b.endereco_pc = a;
        b.pc_valido = 1;
        ok = 0;
        for (int k = 0; k < lim && !ok; k++) begin
            #1;
            ok = b.pc_pronto;
            @(negedge clock);
        end
        b.pc_valido = 0;
    endtask
    task automatic espera_valida(input int lim);
        for (int k = 0; k < lim && !b.inst_valida; k++) @(negedge clock);
        chk("espera_inst_valida", b.inst_valida, 1);
    endtask
    task automatic consome;
        b.inst_pronta = 1;
        @(negedge clock);
        b.inst_pronta = 0;
    endtask
    initial begin
        bit ok, got;
        logic [31:0] a;
        mem_tab[32'h10] = 32'hFE00_0CE3;
        mem_tab[32'h20] = 32'h0000_0033;
        mem_tab[32'h24] = 32'h00A0_0093;
        reset = 1;
        b.pc_valido = 1;
        b.endereco_pc = 32'h10;
        b.flush = 0;
        b.inst_pronta = 1;
        @(negedge clock);
        #3;
        chk("reset_mem_req", b.mem_req, 0);
        chk("reset_mem_endereco", b.mem_endereco, 0);
        chk("reset_inst_valida", b.inst_valida, 0);
        chk("reset_instrucao", b.instrucao, 0);
        chk("reset_inst_endereco", b.inst_endereco, 0);
        chk("reset_imediato", b.imediato, 0);
        chk("reset_flags", {b.eh_desvio, b.desalinhado}, 0);
        @(negedge clock);
        reset = 0;
        b.pc_valido = 0;
        b.inst_pronta = 0;
        #1;
        chk("pos_reset_pc_pronto", b.pc_pronto, 1);
        chk("pos_reset_mem_req", b.mem_req, 0);
        chk("pos_reset_inst_valida", b.inst_valida, 0);
        mon_on = 1;
        resp_on = 1;
        @(negedge clock);
        lat_cfg = 3;
        oferta(32'h10, 5, ok);
        chk("aceita_0x10", ok, 1);
        espera_valida(10);
        chk("busca_instrucao", b.instrucao, 32'hFE00_0CE3);
        chk("busca_endereco", b.inst_endereco, 32'h10);
        chk("busca_imediato", b.imediato, 32'hFFFF_FFF8);
        chk("busca_desvio", b.eh_desvio, 1);
        consome();
        lat_cfg = 0;
        oferta(32'h0, 5, ok);
        chk("aceita_0x0", ok, 1);
        oferta(32'h4, 8, ok);
        chk("aceita_0x4", ok, 1);
        oferta(32'h8, 6, ok);
        chk("rejeita_0x8_cheio", ok, 0);
        consome();
        oferta(32'h8, 4, ok);
        chk("aceita_0x8_apos_pop", ok, 1);
        b.inst_pronta = 1;
        repeat (6) @(negedge clock);
        b.inst_pronta = 0;
        lat_cfg = 3;
        oferta(32'h20, 5, ok);
        chk("aceita_0x20", ok, 1);
        b.flush = 1;
        @(negedge clock);
        b.flush = 0;
        repeat (5) @(negedge clock);
        chk("flush_descarta", b.inst_valida, 0);
        lat_cfg = 1;
        oferta(32'h40, 5, ok);
        chk("aceita_0x40", ok, 1);
        espera_valida(8);
        chk("busca_0x40", b.inst_endereco, 32'h40);
        lat_cfg = 2;
        oferta(32'h24, 5, ok);
        chk("aceita_0x24", ok, 1);
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            got = b.mem_valido;
            if (!got) @(negedge clock);
        end
        chk("resposta_0x24", got, 1);
        consome();
        chk("cabeca_0x24", b.inst_endereco, 32'h24);
        chk("valida_apos_push_pop", b.inst_valida, 1);
        consome();
        chk("contador_era_1", b.inst_valida, 0);
        oferta(32'h6, 3, ok);
        chk("aceita_0x6", ok, 1);
        chk("desal_sem_mem_req", b.mem_req, 0);
        chk("desal_instrucao", b.instrucao, 32'h13);
        chk("desal_flag", b.desalinhado, 1);
        chk("desal_desvio", b.eh_desvio, 0);
        consome();
        lat_cfg = -1;
        spur = 1;
        for (int n = 0; n < 600; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            b.endereco_pc = a;
            b.pc_valido = $urandom_range(0, 1) == 1;
            b.inst_pronta = $urandom_range(0, 2) != 0;
            b.flush = $urandom_range(0, 19) == 0;
            @(negedge clock);
        end
        b.pc_valido = 0;
        b.flush = 0;
        b.inst_pronta = 1;
        repeat (10) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch unit at the consumer end of the PC address path. It accepts each next-instruction address produced by the PC stage, reads the word from instruction memory over a request/response interface of variable latency, and buffers the results in a small FIFO. It presents each instruction to decode with its address, a sign-extended B-type immediate, and a branch flag; these feed back into the PC stage's `imediato` and branch-select inputs.

## Interface
- `PROF`, default 2: FIFO depth in entries; power of two, ≥2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `endereco_pc` in 32: address offered by the PC stage.
- `pc_valido` in 1: `endereco_pc` is valid.
- `pc_pronto` out 1: address accepted this cycle when `pc_valido & pc_pronto`.
- `mem_req` out 1: one-cycle read request strobe.
- `mem_endereco` out 32: read address, held stable from `mem_req` until the response.
- `mem_valido` in 1: response strobe; `mem_dado` is valid.
- `mem_dado` in 32: instruction word.
- `flush` in 1: discard all buffered and in-flight fetches.
- `inst_valida` out 1: FIFO head is valid.
- `inst_pronta` in 1: decode consumes the head when `inst_valida & inst_pronta`.
- `instrucao` out 32: head instruction.
- `inst_endereco` out 32: head address.
- `imediato` out 32: B-type immediate of the head, `{{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}`.
- `eh_desvio` out 1: head opcode `i[6:0] == 7'b1100011`.
- `desalinhado` out 1: head entry came from an address with `[1:0] != 0`.

## Operation
- FSM states:
  - OCIOSO: no request outstanding.
  - ESPERA_MEM: one request outstanding; `descartar` flag marks whether its response is dropped.
- `pc_pronto = (estado==OCIOSO) & (contador < PROF) & ~flush`.
- Accept, aligned address:
  - register `mem_endereco`.
  - assert `mem_req` for the next cycle only.
  - go to ESPERA_MEM.
- Accept, misaligned address:
  - no memory request.
  - push `{addr, 32'h00000013, desalinhado=1}` directly at the accepting edge.
  - stay in OCIOSO.
- ESPERA_MEM response handling:
  - `mem_valido` is sampled in every ESPERA_MEM cycle, including the `mem_req` cycle.
  - On response with `descartar=0`: push `{mem_endereco, mem_dado, 0}`.
  - On response with `descartar=1`: drop it.
  - Either way, return to OCIOSO and clear `descartar`.
- `mem_valido` in OCIOSO is ignored.
- Room reservation: an entry is reserved at acceptance, so a response push never finds the FIFO full.
- Pop: `inst_valida & inst_pronta` removes the head.
- Push and pop in the same cycle: `contador` unchanged; both pointers advance.
- `flush` (priority over push, pop, accept):
  - empties the FIFO (`contador`=0, pointers=0).
  - if in ESPERA_MEM, sets `descartar` and the state stays ESPERA_MEM until the response arrives.
  - a response arriving in the flush cycle itself is dropped.
- `contador` width: `$clog2(PROF)+1`. Pointers wrap modulo PROF.
- Outputs `instrucao`, `inst_endereco`, `imediato`, `eh_desvio`, `desalinhado` come from the FIFO head. All are 0 when the FIFO is empty.

## Timing
- Reset (synchronous): state OCIOSO, FIFO empty, `descartar`=0.
- Output values in the cycle after a reset edge:
  - `mem_req`=0, `mem_endereco`=0, `inst_valida`=0.
  - `pc_pronto`=1 if `flush`=0.
  - all head outputs 0.
- Reset mid-request abandons the outstanding fetch. Responses after reset are ignored because the state is OCIOSO.
- Aligned fetch:
  - acceptance at edge E0.
  - `mem_req` high in cycle E0→E1.
  - response at edge Ek, k≥1.
  - `inst_valida` high from cycle after Ek.
  - minimum 2 edges address-to-valid.
- Misaligned fetch: `inst_valida` in the cycle after acceptance.
- At most one memory request outstanding. Throughput with zero-wait memory: one instruction per 2 cycles.
- `pc_pronto` is low for the whole of ESPERA_MEM, and low when `contador==PROF`.

## Test plan
- Reset: assert `reset` for 2 cycles with `pc_valido`=1 and `mem_valido`=1 → no `mem_req`, `inst_valida`=0, all outputs 0; `pc_pronto`=1 after release.
- Fetch at 3-cycle latency: accept `0x00000010`; memory returns `0xFE000CE3` 3 cycles after `mem_req` → `mem_endereco`=`0x10` held throughout. Head then shows `instrucao`=`0xFE000CE3`, `inst_endereco`=`0x10`, `eh_desvio`=1, `imediato`=`0xFFFFFFF8`.
- Backpressure: `inst_pronta`=0, fetch `0x0`, `0x4`, `0x8` with zero-wait memory → `pc_pronto` drops after 2 entries (PROF=2) and `0x8` is not accepted. Raising `inst_pronta` for one cycle pops `0x0` and `0x8` is then accepted.
- Flush mid-request: accept `0x20`, assert `flush` one cycle later, then respond with `0x00000033` → response dropped, `inst_valida` stays 0, next accept `0x40` fetches normally.
- Simultaneous push/pop at `contador`=1: pop head while the `0x24` response arrives → `contador` stays 1 and the head becomes `0x24`.
- Misaligned: accept `0x00000006` → no `mem_req`; next cycle `instrucao`=`0x00000013`, `desalinhado`=1, `eh_desvio`=0.
